// File: rtl/cp0_pkg.sv
// Purpose: shared CP0 register numbers, bit positions and default vector for the interrupt controller.
// Latency: n/a (constants only).
// Backpressure: n/a.
package cp0_pkg;

  // CP0 register numbers as decoded from MTC0/MFC0
  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  // Bit positions inside STATUS and CAUSE
  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_IP  = 10;

  // Default interrupt handler entry address
  localparam logic [31:0] CP0_VECTOR_DEFAULT = 32'h0000_0004;

endpackage

// File: rtl/cp0_int_ctrl_int_sync_edge.sv
// Purpose: optional 2-flop synchroniser (CP0_INT_SYNC_EN) plus rising-edge detector for int_req.
// Latency: pulse is combinational from the request without the synchroniser, 2 cycles later with it.
// Backpressure: en=0 holds the edge flop so an edge seen during a stall is presented again afterwards.
module int_sync_edge
  import cp0_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_async,
  output logic pulse
);

  logic req_s;

`ifdef CP0_INT_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  // Synchroniser stages always shift; they carry no architectural state
  always_comb begin
    sync1_d = req_async;
    sync2_d = sync1_q;
  end

  // Two-flop synchroniser, cleared by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign req_s = sync2_q;
`else
  // Source is assumed synchronous to clk in this build
  assign req_s = req_async;
`endif

  logic prev_q, prev_d;

  // Remember last sampled level only while state is allowed to advance
  always_comb begin
    prev_d = prev_q;
    if (en) begin
      prev_d = req_s;
    end
  end

  // Edge-detect history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign pulse = req_s & ~prev_q;

endmodule

// File: rtl/cp0_int_ctrl.sv
// Purpose: CP0 interrupt controller (STATUS/CAUSE/EPC, take/ERET redirect); CP0_INT_SYNC_EN adds an input synchroniser.
// Latency: redirect/redirect_pc/flush are combinational; int_req rise to IP is 1 cycle (3 with the synchroniser).
// Backpressure: stall freezes every state update; a pending take waits for the first unstalled valid ID cycle.
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] VECTOR = CP0_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        int_req,
  input  logic [31:0] id_pc,
  input  logic        id_valid,
  input  logic        stall,
  input  logic        eret,
  input  logic        cp0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush
);

  // Mode is encoded directly by EXL
  localparam logic [0:0] ST_RUN = 1'b0;
  localparam logic [0:0] ST_ISR = 1'b1;

  logic        ip_q, ip_d;
  logic        ie_q, ie_d;
  logic [0:0]  exl_q, exl_d;
  logic [31:0] epc_q, epc_d;

  logic edge_pulse;
  logic eret_fire;
  logic take;
  logic unused_wdata;

  int_sync_edge u_sync_edge (
    .clk       (clk),
    .rst       (rst),
    .en        (~stall),
    .req_async (int_req),
    .pulse     (edge_pulse)
  );

  // Only the IE/EXL bits of STATUS are writable; the rest is ignored
  assign unused_wdata = ^cp0_wdata[31:2];

  // ERET has priority; a take blocked by it is re-evaluated next cycle
  always_comb begin
    eret_fire = eret & ~stall;
    take      = ip_q & ie_q & (exl_q == ST_RUN) & id_valid & ~stall & ~eret;
  end

  // PC-mux controls for the take and ERET cycles
  always_comb begin
    redirect    = eret_fire | take;
    flush       = eret_fire | take;
    redirect_pc = eret_fire ? epc_q : VECTOR;
  end

  // MFC0 read mux; unmapped numbers read zero
  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CP0_STATUS: begin
        cp0_rdata[ST_IE]  = ie_q;
        cp0_rdata[ST_EXL] = exl_q[0];
      end
      CP0_CAUSE: cp0_rdata[CA_IP] = ip_q;
      CP0_EPC:   cp0_rdata = epc_q;
      default:   cp0_rdata = '0;
    endcase
  end

  // Next-state: MTC0 first, then ERET/take override, then a new edge re-arms IP
  always_comb begin
    ip_d  = ip_q;
    ie_d  = ie_q;
    exl_d = exl_q;
    epc_d = epc_q;
    if (!stall) begin
      if (cp0_we) begin
        case (cp0_addr)
          CP0_STATUS: begin
            ie_d  = cp0_wdata[ST_IE];
            exl_d = cp0_wdata[ST_EXL];
          end
          CP0_EPC: epc_d = cp0_wdata;
          default: ;
        endcase
      end
      if (eret_fire) begin
        exl_d = ST_RUN;
      end
      if (take) begin
        epc_d = id_pc;
        exl_d = ST_ISR;
        ip_d  = 1'b0;
      end
      if (edge_pulse) begin
        ip_d = 1'b1;
      end
    end
  end

  // Architectural CP0 state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_q  <= 1'b0;
      ie_q  <= 1'b0;
      exl_q <= ST_RUN;
      epc_q <= '0;
    end else begin
      ip_q  <= ip_d;
      ie_q  <= ie_d;
      exl_q <= exl_d;
      epc_q <= epc_d;
    end
  end

endmodule
